// File: rtl/bram_fill_drain_ctrl.sv
// Fill/drain sequencer for the shared BRAM/steer datapath: byte-wide fill on port A, then word drain on port B.
// Optional busy-cycle counter output when BRAM_SEQ_PERF_EN is defined.
module bram_fill_drain_ctrl #(
  parameter int unsigned FILL_DEPTH = 2048,
  parameter int unsigned READ_DEPTH = 512,
  parameter int unsigned SELECT     = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              complete,
  output logic              e_mem_addr_en,
  output logic              w_bram_addr_en,
  output logic              r_bram_addr_en,
  output logic              W_A,
  output logic              EN_A,
  output logic              EN_B,
  output logic              SM_EN,
  output logic [SELECT-1:0] Sel
`ifdef BRAM_SEQ_PERF_EN
  ,
  output logic [31:0]       busy_cycles
`endif
);

  localparam int unsigned FILL_W = $clog2(FILL_DEPTH);
  localparam int unsigned RD_W   = $clog2(READ_DEPTH);
  localparam int unsigned LANES  = 1 << SELECT;

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_DEPTH - 1);
  localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(READ_DEPTH - 1);
  localparam logic [SELECT-1:0] SEL_LAST  = SELECT'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_TURN,
    S_PRIME,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [RD_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [SELECT-1:0]  sel_q, sel_d;

  // State and counter registers
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fill_cnt_q <= '0;
      rd_cnt_q   <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      sel_q      <= sel_d;
    end
  end

  assign Sel = sel_q;

  // Next-state and enable decode; enables are gated by stall in the same cycle
  always_comb begin
    state_d        = state_q;
    fill_cnt_d     = fill_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    sel_d          = sel_q;
    complete       = 1'b0;
    e_mem_addr_en  = 1'b0;
    w_bram_addr_en = 1'b0;
    r_bram_addr_en = 1'b0;
    W_A            = 1'b0;
    EN_A           = 1'b0;
    EN_B           = 1'b0;
    SM_EN          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FILL;
          fill_cnt_d = '0;
        end
      end

      S_FILL: begin
        e_mem_addr_en  = !stall;
        w_bram_addr_en = !stall;
        W_A            = !stall;
        EN_A           = !stall;
        if (!stall) begin
          if (fill_cnt_q == FILL_LAST) begin
            state_d    = S_TURN;
            fill_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end
        end
      end

      // Dead cycle between the last port-A write and the first port-B read
      S_TURN: begin
        state_d = S_PRIME;
      end

      S_PRIME: begin
        EN_B = !stall;
        if (!stall) begin
          state_d  = S_DRAIN;
          sel_d    = '0;
          rd_cnt_d = '0;
        end
      end

      S_DRAIN: begin
        EN_B  = !stall;
        SM_EN = !stall;
        if (!stall) begin
          if (sel_q == SEL_LAST) begin
            sel_d          = '0;
            r_bram_addr_en = (rd_cnt_q != RD_LAST);
            if (rd_cnt_q == RD_LAST) begin
              state_d  = S_DONE;
              rd_cnt_d = '0;
            end else begin
              rd_cnt_d = rd_cnt_q + RD_W'(1);
            end
          end else begin
            sel_d = sel_q + SELECT'(1);
          end
        end
      end

      S_DONE: begin
        complete = 1'b1;
        sel_d    = '0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef BRAM_SEQ_PERF_EN
  logic [31:0] busy_q;

  // Cycles spent outside IDLE in the most recent run, saturating
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (state_d == S_FILL) begin
        busy_q <= '0;
      end
    end else if (busy_q != 32'hFFFF_FFFF) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule
